fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program counter and instruction-fetch stage of the 3BC processor.
- Drives the 10-bit address into the combinational instruction ROM.
- Captures the returned 9-bit instruction and its PC into a fetch register consumed by decode.
- Implements the Start/Done program-run handshake, stall, taken-branch redirect with squash, and halt.

Parameters:
- PC_W, 10, program counter / instruction address width
- INST_W, 9, instruction width
- PROG1_START, 10'd0, start PC when ProgSel=1
- PROG2_START, 10'd256, start PC when ProgSel=2
- PROG3_START, 10'd512, start PC when ProgSel=3

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset_n  input  1  reset, asynchronous, active-low
- Start  input  1  single-cycle pulse: begin running program ProgSel
- ProgSel  input  2  program select; 0 selects PC 0, 1..3 select PROGn_START
- Stall  input  1  decode cannot accept; hold PC and fetch register
- BranchTaken  input  1  decode resolved a taken branch this cycle
- BranchTarget  input  PC_W  absolute branch destination
- Halt  input  1  decode holds a halt instruction this cycle
- InstIn  input  INST_W  instruction returned by ROM for InstAddress
- InstAddress  output  PC_W  current PC, to ROM
- FetchInst  output  INST_W  registered instruction for decode
- FetchPC  output  PC_W  PC of FetchInst
- FetchValid  output  1  FetchInst is a live instruction
- Running  output  1  state==RUN
- Done  output  1  program has halted

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values: PC=0, state IDLE, FetchInst=0, FetchPC=0, FetchValid=0, Done=0, Running=0.
- InstAddress = PC, combinational from the PC register. The ROM is combinational, so InstIn is valid in the same cycle.
- States:
  - IDLE: PC and fetch register hold, FetchValid=0. Start -> PC<=sel_start(ProgSel), Done<=0, go RUN.
  - RUN: per-edge actions in strict priority:
    1. Halt -> FetchValid<=0, Done<=1, PC held, go HALTED.
    2. BranchTaken -> PC<=BranchTarget, FetchValid<=0 (squash the wrong-path instruction fetched this cycle).
    3. Stall -> PC, FetchInst, FetchPC, FetchValid all held.
    4. Otherwise -> FetchInst<=InstIn, FetchPC<=PC, FetchValid<=1, PC<=PC+1.
  - HALTED: Done=1, everything held. Start -> identical to Start in IDLE (restart, Done<=0).
- Start in RUN is ignored.
- Halt and BranchTaken are only sampled in RUN; they are ignored in IDLE and HALTED.
- Latency:
  - Start at edge k: PC=start at k.
  - ROM[start] appears in the fetch register (FetchValid=1) at edge k+1.
  - Each taken branch costs exactly one bubble cycle.
- PC arithmetic is PC_W-bit unsigned; 1023+1 wraps to 0 with no flag.
- Halt asserted together with Stall or BranchTaken: Halt wins.
- Reset_n asserted mid-RUN: immediate return to reset values regardless of Clk. No partial state survives.

Decomposition:
- Shared package:
  - fetch_state_t enum {IDLE, RUN, HALTED}
  - PC_W and INST_W constants
  - the three program start-address constants, shared with the assembler/testbench
  - a function prog_start(ProgSel) returning the start PC
- Single module; no sub-module needed. Keep the PC next-value mux as one always_comb and the state/fetch register as one always_ff.

Test Plan:
- Reset, then Start with ProgSel=2, ROM[256]=9'h0A5 -> PC=256 after edge 1; at edge 2 FetchInst=0x0A5, FetchPC=256, FetchValid=1, InstAddress=257.
- Free-run from PC=1022 with no stall -> FetchPC sequence 1022, 1023, 0, 1 (wrap, no glitch on FetchValid).
- Stall held 3 cycles at PC=10 -> PC, FetchInst, FetchPC frozen for 3 edges; on release FetchPC advances to 10 then 11.
- BranchTaken with BranchTarget=40 while PC=12 -> next edge FetchValid=0 and PC=40; following edge FetchPC=40, FetchValid=1.
- Halt and BranchTaken asserted together -> Done=1, FetchValid=0, PC unchanged. A subsequent Start with ProgSel=1 -> PC=0, Done=0, Running=1.
- Reset_n pulsed low mid-cycle during RUN -> outputs return to reset values asynchronously. Start pulsed during RUN (no reset) -> no effect on PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 3BC fetch stage: widths, program entry points and
// the fetch controller state encoding.
package fetch_unit_pkg;

  localparam int PC_W   = 10;
  localparam int INST_W = 9;

  localparam logic [PC_W-1:0] PROG1_START = 10'd0;
  localparam logic [PC_W-1:0] PROG2_START = 10'd256;
  localparam logic [PC_W-1:0] PROG3_START = 10'd512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  // ProgSel 0 is a raw start at address zero; 1..3 select a program slot.
  function automatic logic [PC_W-1:0] prog_start(input logic [1:0] prog_sel);
    logic [PC_W-1:0] start_pc;
    case (prog_sel)
      2'd1:    start_pc = PROG1_START;
      2'd2:    start_pc = PROG2_START;
      2'd3:    start_pc = PROG3_START;
      default: start_pc = '0;
    endcase
    return start_pc;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch register of the 3BC processor. Drives the
// combinational ROM and hands {instruction, PC} to decode.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [PC_W-1:0]   BranchTarget,
  input  logic              Halt,
  input  logic [INST_W-1:0] InstIn,
  output logic [PC_W-1:0]   InstAddress,
  output logic [INST_W-1:0] FetchInst,
  output logic [PC_W-1:0]   FetchPC,
  output logic              FetchValid,
  output logic              Running,
  output logic              Done
);

  fetch_state_t      state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [INST_W-1:0] fetch_inst_reg, fetch_inst_next;
  logic [PC_W-1:0]   fetch_pc_reg, fetch_pc_next;
  logic              fetch_valid_reg, fetch_valid_next;
  logic              done_reg, done_next;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    fetch_inst_next  = fetch_inst_reg;
    fetch_pc_next    = fetch_pc_reg;
    fetch_valid_next = fetch_valid_reg;
    done_next        = done_reg;

    case (state_reg)
      IDLE, HALTED: begin
        if (Start) begin
          pc_next    = prog_start(ProgSel);
          done_next  = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Halt outranks a redirect or stall issued in the same cycle.
        if (Halt) begin
          fetch_valid_next = 1'b0;
          done_next        = 1'b1;
          state_next       = HALTED;
        end else if (BranchTaken) begin
          // The instruction on InstIn is wrong-path; drop it and redirect.
          pc_next          = BranchTarget;
          fetch_valid_next = 1'b0;
        end else if (!Stall) begin
          fetch_inst_next  = InstIn;
          fetch_pc_next    = pc_reg;
          fetch_valid_next = 1'b1;
          pc_next          = pc_reg + PC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      fetch_inst_reg  <= '0;
      fetch_pc_reg    <= '0;
      fetch_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fetch_inst_reg  <= fetch_inst_next;
      fetch_pc_reg    <= fetch_pc_next;
      fetch_valid_reg <= fetch_valid_next;
      done_reg        <= done_next;
    end
  end

  assign InstAddress = pc_reg;
  assign FetchInst   = fetch_inst_reg;
  assign FetchPC     = fetch_pc_reg;
  assign FetchValid  = fetch_valid_reg;
  assign Running     = (state_reg == RUN);
  assign Done        = done_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {FetchPC, FetchInst}
// per live cycle, a negedge monitor pops and compares.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [1:0]        ProgSel = 2'd0;
  logic              Stall = 1'b0;
  logic              BranchTaken = 1'b0;
  logic [PC_W-1:0]   BranchTarget = '0;
  logic              Halt = 1'b0;
  logic [INST_W-1:0] InstIn;
  logic [PC_W-1:0]   InstAddress;
  logic [INST_W-1:0] FetchInst;
  logic [PC_W-1:0]   FetchPC;
  logic              FetchValid;
  logic              Running;
  logic              Done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PC_W+INST_W-1:0] exp_q[$];
  logic [PC_W+INST_W-1:0] mon_e;

  fetch_unit dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .ProgSel(ProgSel),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Halt(Halt), .InstIn(InstIn), .InstAddress(InstAddress),
    .FetchInst(FetchInst), .FetchPC(FetchPC), .FetchValid(FetchValid),
    .Running(Running), .Done(Done)
  );

  // ROM contents: address low 9 bits XOR 0x1A5 (so ROM[256] = 0x0A5).
  assign InstIn = InstAddress[8:0] ^ 9'h1A5;

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // One clock; then check FetchValid/InstAddress and queue the expected fetch.
  task automatic cyc(input string name, input logic ev, input logic [PC_W-1:0] epc,
                     input logic [INST_W-1:0] einst, input logic [PC_W-1:0] eaddr);
    @(posedge Clk);
    #1;
    check({name, " valid"}, 32'(FetchValid), 32'(ev));
    check({name, " addr"}, 32'(InstAddress), 32'(eaddr));
    if (ev) exp_q.push_back({epc, einst});
    $display("cycle %-14s addr=%0d valid=%0b fpc=%0d finst=0x%0h", name, InstAddress,
             FetchValid, FetchPC, FetchInst);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && FetchValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL monitor: unexpected live fetch pc=%0d required none", FetchPC);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch_pc", 32'(FetchPC), 32'(mon_e[PC_W+INST_W-1:INST_W]));
        check("fetch_inst", 32'(FetchInst), 32'(mon_e[INST_W-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached required finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    Reset_n = 1'b1;
    check("rst addr", 32'(InstAddress), 32'd0);
    check("rst valid", 32'(FetchValid), 32'd0);
    check("rst done", 32'(Done), 32'd0);
    check("rst running", 32'(Running), 32'd0);
    check("rst finst", 32'(FetchInst), 32'd0);
    check("rst fpc", 32'(FetchPC), 32'd0);

    // Start program 2 at 256
    Start = 1'b1; ProgSel = 2'd2;
    cyc("start2", 1'b0, 0, 0, 10'd256);
    Start = 1'b0;
    check("start2 running", 32'(Running), 32'd1);
    cyc("first fetch", 1'b1, 10'd256, 9'h0A5, 10'd257);

    // Redirect to 1022 and free-run across the wrap
    BranchTaken = 1'b1; BranchTarget = 10'd1022;
    cyc("br 1022", 1'b0, 0, 0, 10'd1022);
    BranchTaken = 1'b0;
    cyc("run 1022", 1'b1, 10'd1022, 9'h05B, 10'd1023);
    cyc("run 1023", 1'b1, 10'd1023, 9'h05A, 10'd0);
    cyc("run 0", 1'b1, 10'd0, 9'h1A5, 10'd1);
    cyc("run 1", 1'b1, 10'd1, 9'h1A4, 10'd2);

    // Stall three cycles with PC=10
    BranchTaken = 1'b1; BranchTarget = 10'd8;
    cyc("br 8", 1'b0, 0, 0, 10'd8);
    BranchTaken = 1'b0;
    cyc("run 8", 1'b1, 10'd8, 9'h1AD, 10'd9);
    cyc("run 9", 1'b1, 10'd9, 9'h1AC, 10'd10);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall", 1'b1, 10'd9, 9'h1AC, 10'd10);
    Stall = 1'b0;
    cyc("run 10", 1'b1, 10'd10, 9'h1AF, 10'd11);
    cyc("run 11", 1'b1, 10'd11, 9'h1AE, 10'd12);

    // Taken branch to 40 from PC=12: one bubble
    BranchTaken = 1'b1; BranchTarget = 10'd40;
    cyc("br 40", 1'b0, 0, 0, 10'd40);
    BranchTaken = 1'b0;
    cyc("run 40", 1'b1, 10'd40, 9'h18D, 10'd41);

    // Halt with a simultaneous branch: halt wins
    Halt = 1'b1; BranchTaken = 1'b1; BranchTarget = 10'd100;
    cyc("halt", 1'b0, 0, 0, 10'd41);
    check("halt done", 32'(Done), 32'd1);
    check("halt running", 32'(Running), 32'd0);
    Halt = 1'b0;
    cyc("halted hold", 1'b0, 0, 0, 10'd41);
    check("halted done", 32'(Done), 32'd1);
    BranchTaken = 1'b0;

    // Restart program 1
    Start = 1'b1; ProgSel = 2'd1;
    cyc("restart", 1'b0, 0, 0, 10'd0);
    Start = 1'b0;
    check("restart done", 32'(Done), 32'd0);
    check("restart running", 32'(Running), 32'd1);
    cyc("restart fetch", 1'b1, 10'd0, 9'h1A5, 10'd1);

    // Start while running is ignored
    Start = 1'b1; ProgSel = 2'd2;
    cyc("start in run", 1'b1, 10'd1, 9'h1A4, 10'd2);
    Start = 1'b0;

    // Asynchronous reset between clock edges
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst addr", 32'(InstAddress), 32'd0);
    check("arst valid", 32'(FetchValid), 32'd0);
    check("arst fpc", 32'(FetchPC), 32'd0);
    check("arst finst", 32'(FetchInst), 32'd0);
    check("arst running", 32'(Running), 32'd0);
    check("arst done", 32'(Done), 32'd0);
    #10;
    Reset_n = 1'b1;
    cyc("post rst idle", 1'b0, 0, 0, 10'd0);
    check("post rst running", 32'(Running), 32'd0);

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
